// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a sticky
// misaligned-redirect fault flag, in front of a 64-word combinational imem.
module fetch_stage #(
  parameter logic [31:0]      RESET_PC  = 32'h0000_0000,
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [5:0]       imem_addr,
  input  logic [WIDTH-1:0] imem_instr,
  output logic [31:0]      pc,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic [WIDTH-1:0] if_id_instr,
  output logic             misaligned_fault
);

  logic [31:0]      pc_d;
  logic             valid_d;
  logic [31:0]      if_id_pc_d;
  logic [WIDTH-1:0] instr_d;
  logic             fault_d;
  logic [31:0]      pc_plus4;

  assign imem_addr = pc[7:2];
  assign pc_plus4  = pc + 32'd4;

  // Redirect beats flush beats stall; a flush only kills IF/ID, the PC still
  // advances unless the hazard unit is also holding.
  always_comb begin
    pc_d       = pc;
    valid_d    = if_id_valid;
    if_id_pc_d = if_id_pc;
    instr_d    = if_id_instr;
    fault_d    = misaligned_fault;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      if_id_pc_d = pc;
      if (redirect_pc[1:0] != 2'b00) fault_d = 1'b1;
    end else if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (!stall) pc_d = pc_plus4;
    end else if (!stall) begin
      pc_d       = pc_plus4;
      instr_d    = imem_instr;
      if_id_pc_d = pc;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc               <= RESET_PC;
      if_id_valid      <= 1'b0;
      if_id_pc         <= '0;
      if_id_instr      <= NOP_INSTR;
      misaligned_fault <= 1'b0;
    end else begin
      pc               <= pc_d;
      if_id_valid      <= valid_d;
      if_id_pc         <= if_id_pc_d;
      if_id_instr      <= instr_d;
      misaligned_fault <= fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes model predictions per edge,
// a monitor pops and compares them after each rising edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        misaligned_fault;

  logic [31:0] mem [64];
  assign imem_instr = mem[imem_addr];

  fetch_stage #(.RESET_PC(32'h0000_0000), .WIDTH(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .pc(pc),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .misaligned_fault(misaligned_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m.pc = 32'h0; m.v = 1'b0; m.ipc = 32'h0; m.instr = NOP; m.fault = 1'b0;
  endtask

  // Drives one cycle's inputs at a falling edge, predicts the state after the
  // next rising edge, then waits for the following falling edge.
  task automatic step(input logic s, input logic f, input logic rv, input logic [31:0] rpc);
    exp_t n;
    stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
    n = m;
    if (rv) begin
      n.pc = rpc & 32'hFFFF_FFFC; n.v = 1'b0; n.instr = NOP; n.ipc = m.pc;
      if (rpc % 4 != 0) n.fault = 1'b1;
    end else if (f) begin
      n.v = 1'b0; n.instr = NOP;
      if (!s) n.pc = m.pc + 32'd4;
    end else if (!s) begin
      n.instr = mem[(m.pc / 4) % 64]; n.ipc = m.pc; n.v = 1'b1; n.pc = m.pc + 32'd4;
    end
    m = n;
    q.push_back(n);
    @(negedge clk);
  endtask

  task automatic run(input int unsigned k);
    for (int unsigned i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Asserts reset mid-cycle, checks the outputs change without a clock edge,
  // and returns at a falling edge with reset released.
  task automatic pulse_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_pc", pc, m.pc);
    check("async_rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("async_rst_ipc", if_id_pc, 32'h0);
    check("async_rst_instr", if_id_instr, NOP);
    check("async_rst_fault", {31'b0, misaligned_fault}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc", pc, e.pc);
        check("imem_addr", {26'b0, imem_addr}, {26'b0, e.pc[7:2]});
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.v});
        check("if_id_pc", if_id_pc, e.ipc);
        check("if_id_instr", if_id_instr, e.instr);
        check("misaligned_fault", {31'b0, misaligned_fault}, {31'b0, e.fault});
      end
    end
  end

  initial begin : stimulus
    int unsigned r;
    logic [31:0] rpc;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    model_reset();
    @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_instr", if_id_instr, NOP);
    check("rst_ipc", if_id_pc, 32'h0);
    check("rst_fault", {31'b0, misaligned_fault}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run(2);
    check("run_pc_is_8", pc, 32'h8);
    check("run_word1", if_id_instr, 32'h00A0_0113);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_hold_ipc", if_id_pc, 32'h4);
    run(1);
    step(1'b1, 1'b0, 1'b1, 32'h20);
    check("redir_stall_pc", pc, 32'h20);
    run(1);
    check("redir_next_ipc", if_id_pc, 32'h20);
    step(1'b0, 1'b0, 1'b1, 32'h10);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("flush_stall_pc", pc, 32'h10);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h22);
    check("misalign_pc", pc, 32'h20);
    check("misalign_fault", {31'b0, misaligned_fault}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    step(1'b0, 1'b0, 1'b1, 32'hFC);
    check("addr_63", {26'b0, imem_addr}, 32'd63);
    run(1);
    check("wrap_pc_100", pc, 32'h100);
    check("wrap_addr_0", {26'b0, imem_addr}, 32'd0);
    check("fault_sticky", {31'b0, misaligned_fault}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(2);
    check("pc_mod_wrap", pc, 32'h0);
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h1C);
    pulse_reset();

    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: rpc = $urandom;
        1: rpc = $urandom_range(0, 255);
        2: rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, rpc);
      if (i % 150 == 149) pulse_reset();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
